axi4l_image_master: RTL
=======================

AXI4L_IMAGE_MASTER -- requirements
Module: axi4l_image_master

Interface
REQ-001 Parameter AXI_DATA_WIDTH, default 32: AXI4-Lite data bus width.
REQ-002 Parameter AXI_ADDR_WIDTH, default 32: AXI4-Lite address bus width.
REQ-003 Parameter IMAGE_SIZE, default 256: pixels per image.
REQ-004 Parameter PIXEL_BITS, default 8: pixel width.
REQ-005 Parameter M, default 8: inferred-digit width.
REQ-006 Parameter BASE_ADDR, default 0: address of pixel 0; flag register at BASE_ADDR+IMAGE_SIZE.
REQ-007 Parameter RESULT_ADDR, default 32'h104: read address of the inferred-digit register.
REQ-008 Parameter SETTLE_CYCLES, default 16: idle cycles between flag set and result read.
REQ-009 ACLK  in  1  clock; one clock domain, all logic on rising edge.
REQ-010 ARESETN  in  1  asynchronous active-low reset.
REQ-011 START  in  1  single-cycle request to transfer one image; ignored unless BUSY=0.
REQ-012 PIX_VALID / PIX_READY  in / out  1 / 1  pixel-source handshake.
REQ-013 PIX_DATA  in  PIXEL_BITS  next pixel, index order 0..IMAGE_SIZE-1.
REQ-014 AWADDR, AWPROT(3), AWVALID out; AWREADY in  AXI4-Lite write-address channel.
REQ-015 WDATA, WSTRB(AXI_DATA_WIDTH/8), WVALID out; WREADY in  write-data channel.
REQ-016 BRESP(2), BVALID in; BREADY out  write-response channel.
REQ-017 ARADDR, ARPROT(3), ARVALID out; ARREADY in  read-address channel.
REQ-018 RDATA, RRESP(2), RVALID in; RREADY out  read-data channel.
REQ-019 BUSY  out  1  high from accepted START until DONE cycle inclusive.
REQ-020 DONE  out  1  single-cycle pulse when result is captured.
REQ-021 DIGIT  out  M  RDATA[M-1:0] captured at the read handshake; held until next capture.
REQ-022 ERROR  out  1  sticky; set on any BRESP or RRESP != 2'b00; cleared on accepted START.

Function
REQ-023 States SHALL be IDLE, CLR, PIX, SET, SETTLE, READ, DONE; IDLE->CLR on START.
REQ-024 Each write (CLR, PIX, SET) SHALL assert AWVALID and WVALID in the same cycle; each drops independently after its own handshake (xVALID&&xREADY), and address/data/strobe SHALL stay stable while valid.
REQ-025 A write SHALL complete only at BVALID&&BREADY; BREADY high only while a response is awaited; at most one write outstanding.
REQ-026 CLR: AWADDR=BASE_ADDR+IMAGE_SIZE, WDATA=0, WSTRB=all ones; on response -> PIX, pixel counter=0.
REQ-027 PIX: PIX_READY SHALL pulse one cycle when PIX_VALID=1 and no write is active; the captured pixel is written to AWADDR=BASE_ADDR+counter, WDATA zero-extended, WSTRB=4'b0001.
REQ-028 PIX: counter increments on each write response; after response for index IMAGE_SIZE-1 -> SET; counter width $clog2(IMAGE_SIZE)+1, no wrap.
REQ-029 PIX with PIX_VALID=0: no AXI activity, state held indefinitely.
REQ-030 SET: flag address, WDATA=1, WSTRB=all ones; on response -> SETTLE.
REQ-031 SETTLE: count exactly SETTLE_CYCLES cycles, then -> READ.
REQ-032 READ: ARVALID=1, ARADDR=RESULT_ADDR until ARREADY; then RREADY=1 until RVALID; capture DIGIT at RVALID&&RREADY -> DONE.
REQ-033 DONE: DONE=1 for one cycle -> IDLE.
REQ-034 AWPROT=ARPROT=3'b000 always.
REQ-035 Error responses SHALL NOT abort the sequence; ERROR is set and the sequence continues.
REQ-036 START while BUSY=1 SHALL be ignored.
REQ-037 Handshakes where READY precedes, coincides with or follows VALID by any number of cycles SHALL all complete correctly.

Reset
REQ-038 ARESETN low SHALL asynchronously force IDLE, counters 0, AWVALID/WVALID/BREADY/ARVALID/RREADY/PIX_READY/BUSY/DONE/ERROR=0, DIGIT=0.
REQ-039 Reset mid-transfer SHALL abandon the sequence with no resume; next START restarts at CLR.

Verification
REQ-040 Ready-always slave, IMAGE_SIZE=256, pixels i -> 258 writes: flag=0, pixel i to addr i with WDATA=i, flag=1 at 256; read 0x104 returns 7 -> DIGIT=7, one DONE pulse.
REQ-041 AWREADY delayed 3 cycles, WREADY immediate (and swapped): exactly one AW and one W handshake per write, outputs stable while waiting.
REQ-042 BREADY back-pressure: BVALID held 5 cycles before response -> no new AWVALID until response accepted.
REQ-043 PIX_VALID low for 10 cycles at pixel 100 -> no AXI traffic in that interval, pixel 100 written afterwards at addr 100.
REQ-044 BRESP=2'b10 on pixel 5 -> ERROR=1, remaining writes proceed, DONE still pulses; next START clears ERROR.
REQ-045 ARESETN asserted during pixel 50 write -> all outputs at reset values immediately; new START begins with flag clear write.

Source files
------------

// File: rtl/axi4l_image_master.sv
// Purpose: streams one image over AXI4-Lite (flag clear, pixels, flag set), waits, then reads back the inferred digit.
// Latency: one write launches on the edge after its trigger; SETTLE_CYCLES idle cycles separate the flag-set response and ARVALID.
// Backpressure: one write outstanding; pixel source is stalled (PIX_READY low) until the previous write response is accepted.
module axi4l_image_master #(
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        IMAGE_SIZE     = 256,
  parameter int                        PIXEL_BITS     = 8,
  parameter int                        M              = 8,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] RESULT_ADDR    = 'h104,
  parameter int                        SETTLE_CYCLES  = 16
) (
  input  logic                          i_aclk,
  input  logic                          i_aresetn,
  input  logic                          i_start,
  input  logic                          i_pix_valid,
  output logic                          o_pix_ready,
  input  logic [PIXEL_BITS-1:0]         i_pix_data,
  output logic [AXI_ADDR_WIDTH-1:0]     o_awaddr,
  output logic [2:0]                    o_awprot,
  output logic                          o_awvalid,
  input  logic                          i_awready,
  output logic [AXI_DATA_WIDTH-1:0]     o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   o_wstrb,
  output logic                          o_wvalid,
  input  logic                          i_wready,
  input  logic [1:0]                    i_bresp,
  input  logic                          i_bvalid,
  output logic                          o_bready,
  output logic [AXI_ADDR_WIDTH-1:0]     o_araddr,
  output logic [2:0]                    o_arprot,
  output logic                          o_arvalid,
  input  logic                          i_arready,
  input  logic [AXI_DATA_WIDTH-1:0]     i_rdata,
  input  logic [1:0]                    i_rresp,
  input  logic                          i_rvalid,
  output logic                          o_rready,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [M-1:0]                  o_digit,
  output logic                          o_error
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int CW     = $clog2(IMAGE_SIZE) + 1;
  localparam int SW     = $clog2(SETTLE_CYCLES + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_PIX, S_SET, S_SETTLE, S_READ, S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [CW-1:0]             r_cnt;
  logic [SW-1:0]             r_settle;
  logic                      r_awvalid;
  logic                      r_wvalid;
  logic                      r_wr_active;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]         r_wstrb;
  logic                      r_arvalid;
  logic                      r_rd_active;
  logic [M-1:0]              r_digit;
  logic                      r_error;

  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_b_hs;
  logic                      w_ar_hs;
  logic                      w_r_hs;
  logic                      w_pix_hs;
  logic                      w_start_ok;
  logic                      w_last_pix;
  logic                      w_settle_done;
  logic                      w_wr_launch;
  logic                      w_rd_launch;
  logic [AXI_ADDR_WIDTH-1:0] w_wr_addr;
  logic [AXI_DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]         w_wr_strb;
  logic                      w_unused_rdata;

  // Handshake and sequencing qualifiers
  assign o_bready      = r_wr_active & ~r_awvalid & ~r_wvalid;
  assign o_rready      = r_rd_active & ~r_arvalid;
  assign o_pix_ready   = (r_state == S_PIX) & ~r_wr_active & i_pix_valid;
  assign w_aw_hs       = r_awvalid & i_awready;
  assign w_w_hs        = r_wvalid & i_wready;
  assign w_b_hs        = o_bready & i_bvalid;
  assign w_ar_hs       = r_arvalid & i_arready;
  assign w_r_hs        = o_rready & i_rvalid;
  assign w_pix_hs      = o_pix_ready;
  assign w_start_ok    = (r_state == S_IDLE) & i_start;
  assign w_last_pix    = (r_cnt == CW'(IMAGE_SIZE - 1));
  assign w_settle_done = (r_settle == SW'(SETTLE_CYCLES - 1));
  // Writes launch on the edge that enters CLR or SET, or on a pixel handshake
  assign w_wr_launch   = w_start_ok | ((r_state == S_PIX) & w_b_hs & w_last_pix) | w_pix_hs;
  assign w_rd_launch   = (r_state == S_SETTLE) & w_settle_done;

  assign o_awaddr  = r_awaddr;
  assign o_awprot  = 3'b000;
  assign o_awvalid = r_awvalid;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;
  assign o_wvalid  = r_wvalid;
  assign o_araddr  = RESULT_ADDR;
  assign o_arprot  = 3'b000;
  assign o_arvalid = r_arvalid;
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_digit   = r_digit;
  assign o_error   = r_error;

  // Only the low M bits of read data carry the digit
  assign w_unused_rdata = &{1'b0, i_rdata};

  // State register
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start)                 w_next = S_CLR;
      S_CLR:    if (w_b_hs)                  w_next = S_PIX;
      S_PIX:    if (w_b_hs && w_last_pix)    w_next = S_SET;
      S_SET:    if (w_b_hs)                  w_next = S_SETTLE;
      S_SETTLE: if (w_settle_done)           w_next = S_READ;
      S_READ:   if (w_r_hs)                  w_next = S_DONE;
      S_DONE:                                w_next = S_IDLE;
      default:                               w_next = S_IDLE;
    endcase
  end

  // Payload of the write being launched: pixel write, or flag write (0 from IDLE, 1 from last pixel)
  always_comb begin
    w_wr_addr = BASE_ADDR + AXI_ADDR_WIDTH'(IMAGE_SIZE);
    w_wr_data = '0;
    w_wr_strb = '1;
    if (w_pix_hs) begin
      w_wr_addr = BASE_ADDR + AXI_ADDR_WIDTH'(r_cnt);
      w_wr_data = AXI_DATA_WIDTH'(i_pix_data);
      w_wr_strb = STRB_W'(1);
    end else if (r_state == S_PIX) begin
      w_wr_data = AXI_DATA_WIDTH'(1);
    end
  end

  // Write channel: AW and W rise together, each drops on its own handshake
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_wr_active <= 1'b0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
    end else if (w_wr_launch) begin
      r_awvalid   <= 1'b1;
      r_wvalid    <= 1'b1;
      r_wr_active <= 1'b1;
      r_awaddr    <= w_wr_addr;
      r_wdata     <= w_wr_data;
      r_wstrb     <= w_wr_strb;
    end else begin
      if (w_aw_hs) r_awvalid   <= 1'b0;
      if (w_w_hs)  r_wvalid    <= 1'b0;
      if (w_b_hs)  r_wr_active <= 1'b0;
    end
  end

  // Pixel index: cleared at start, advanced by each pixel write response, never wraps
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn)                       r_cnt <= '0;
    else if (w_start_ok)                  r_cnt <= '0;
    else if ((r_state == S_PIX) && w_b_hs) r_cnt <= r_cnt + 1'b1;
  end

  // Settle counter runs only while in SETTLE
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn)                r_settle <= '0;
    else if (r_state == S_SETTLE)  r_settle <= r_settle + 1'b1;
    else                           r_settle <= '0;
  end

  // Read channel: AR until accepted, then R ready until data arrives
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_arvalid   <= 1'b0;
      r_rd_active <= 1'b0;
    end else if (w_rd_launch) begin
      r_arvalid   <= 1'b1;
      r_rd_active <= 1'b1;
    end else begin
      if (w_ar_hs) r_arvalid   <= 1'b0;
      if (w_r_hs)  r_rd_active <= 1'b0;
    end
  end

  // Digit captured at the read-data handshake and held
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn)  r_digit <= '0;
    else if (w_r_hs) r_digit <= i_rdata[M-1:0];
  end

  // Sticky error on any non-OKAY response, cleared by an accepted start
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn)                                              r_error <= 1'b0;
    else if (w_start_ok)                                         r_error <= 1'b0;
    else if ((w_b_hs && i_bresp != 2'b00) || (w_r_hs && i_rresp != 2'b00)) r_error <= 1'b1;
  end

endmodule
